// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage with IF/ID register; optional syscall halt via IFETCH_SYSCALL_HALT_EN
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IMEM_AW  = 10,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        IR,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic               id_valid,
    output logic [31:0]        fetch_count,
    output logic               halted
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [0:0]  state_q, state_d;
    logic [31:0] pc_plus4;
    logic        halt_now;
    logic        is_syscall;
    logic        unused_redirect_lsb;

    // Byte-offset bits of the redirect target are dropped when the PC is loaded.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign pc_plus4 = pc_q + 32'd4;

`ifdef IFETCH_SYSCALL_HALT_EN
    assign halt_now   = (state_q == ST_HALT);
    assign is_syscall = (imem_rdata[31:26] == 6'd0) && (imem_rdata[5:0] == 6'b001100);
`else
    assign halt_now   = 1'b0;
    assign is_syscall = 1'b0;
`endif

    // Next-state selection: redirect > flush > stall > (halted bubble | normal advance)
    always_comb begin
        pc_d          = pc_q;
        ir_d          = ir_q;
        id_pc_d       = id_pc_q;
        id_pc4_d      = id_pc4_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;
        state_d       = state_q;
        if (redirect) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            ir_d       = NOP_WORD;
            id_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else if (flush) begin
            ir_d       = NOP_WORD;
            id_valid_d = 1'b0;
            // The word fetched this cycle is dropped, but the PC still moves on.
            if (!stall && !halt_now) begin
                pc_d = pc_plus4;
            end
        end else if (stall) begin
            pc_d = pc_q;
        end else if (halt_now) begin
            ir_d       = NOP_WORD;
            id_valid_d = 1'b0;
        end else begin
            ir_d          = imem_rdata;
            id_pc_d       = pc_q;
            id_pc4_d      = pc_plus4;
            id_valid_d    = 1'b1;
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
            if (is_syscall) begin
                state_d = ST_HALT;
            end
        end
    end

    // PC, IF/ID register and halt state; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            ir_q          <= NOP_WORD;
            id_pc_q       <= 32'd0;
            id_pc4_q      <= 32'd4;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
            state_q       <= ST_RUN;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            id_pc_q       <= id_pc_d;
            id_pc4_q      <= id_pc4_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
            state_q       <= state_d;
        end
    end

    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign IR          = ir_q;
    assign id_pc       = id_pc_q;
    assign id_pc4      = id_pc4_q;
    assign id_valid    = id_valid_q;
    assign fetch_count = fetch_count_q;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - directed scoreboard bench for ifetch_stage
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IR, id_pc, id_pc4, fetch_count;
    logic        id_valid, halted;

    logic [31:0] rom [0:1023];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        v;
        logic [31:0] cnt;
        logic [9:0]  addr;
        logic        h;
    } exp_t;

    exp_t sb[$];

    ifetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .IR          (IR),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .fetch_count (fetch_count),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    assign imem_rdata = rom[imem_addr];

    function automatic logic [31:0] rv(input int i);
        return {16'hA5A5, 16'(i)};
    endfunction

    function automatic exp_t mk(input logic [31:0] ir, input logic [31:0] pc, input logic v,
                                input logic [31:0] cnt, input logic [9:0] addr, input logic h);
        exp_t e;
        e.ir = ir; e.pc = pc; e.v = v; e.cnt = cnt; e.addr = addr; e.h = h;
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e);
        logic [31:0] pc4;
        pc4 = e.pc + 32'd4;
        total++;
        assert (IR === e.ir) else begin bad++; $error("FAIL %s IR got=%h exp=%h", tag, IR, e.ir); end
        total++;
        assert (id_pc === e.pc) else begin bad++; $error("FAIL %s id_pc got=%h exp=%h", tag, id_pc, e.pc); end
        total++;
        assert (id_pc4 === pc4) else begin bad++; $error("FAIL %s id_pc4 got=%h exp=%h", tag, id_pc4, pc4); end
        total++;
        assert (id_valid === e.v) else begin bad++; $error("FAIL %s id_valid got=%b exp=%b", tag, id_valid, e.v); end
        total++;
        assert (fetch_count === e.cnt) else begin bad++; $error("FAIL %s fetch_count got=%0d exp=%0d", tag, fetch_count, e.cnt); end
        total++;
        assert (imem_addr === e.addr) else begin bad++; $error("FAIL %s imem_addr got=%h exp=%h", tag, imem_addr, e.addr); end
        total++;
        assert (halted === e.h) else begin bad++; $error("FAIL %s halted got=%b exp=%b", tag, halted, e.h); end
    endtask

    // Drive one cycle of hazard inputs, push its expectation, sample after the edge.
    task automatic step(input string tag, input logic r, input logic s, input logic f,
                        input logic rd, input logic [31:0] rpc, input exp_t e);
        exp_t got;
        @(negedge clk);
        rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        total++;
        assert (sb.size() > 0) else begin bad++; $error("FAIL %s scoreboard empty", tag); end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check(tag, got);
        end
    endtask

    logic [31:0] last_pc;
    logic [31:0] cnt;

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = rv(i);
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

        step("reset0", 1, 0, 0, 0, 0, mk(32'h0, 32'h0, 0, 0, 10'h0, 0));
        step("reset1", 1, 0, 0, 0, 0, mk(32'h0, 32'h0, 0, 0, 10'h0, 0));

        step("fetchA", 0, 0, 0, 0, 0, mk(rv(0), 32'h3000, 1, 1, 10'h1, 0));
        step("fetchB", 0, 0, 0, 0, 0, mk(rv(1), 32'h3004, 1, 2, 10'h2, 0));
        step("stall1", 0, 1, 0, 0, 0, mk(rv(1), 32'h3004, 1, 2, 10'h2, 0));
        step("stall2", 0, 1, 0, 0, 0, mk(rv(1), 32'h3004, 1, 2, 10'h2, 0));
        step("fetchC", 0, 0, 0, 0, 0, mk(rv(2), 32'h3008, 1, 3, 10'h3, 0));
        step("fetchD", 0, 0, 0, 0, 0, mk(rv(3), 32'h300C, 1, 4, 10'h4, 0));

        step("redir3043", 0, 0, 0, 1, 32'h0000_3043, mk(32'h0, 32'h300C, 0, 4, 10'h10, 0));
        step("tgt3040", 0, 0, 0, 0, 0, mk(rv(16), 32'h3040, 1, 5, 10'h11, 0));
        step("tgt3044", 0, 0, 0, 0, 0, mk(rv(17), 32'h3044, 1, 6, 10'h12, 0));

        step("redir3008", 0, 1, 1, 1, 32'h0000_3008, mk(32'h0, 32'h3044, 0, 6, 10'h2, 0));
        step("fetchC2", 0, 0, 0, 0, 0, mk(rv(2), 32'h3008, 1, 7, 10'h3, 0));
        step("stallflush", 0, 1, 1, 0, 0, mk(32'h0, 32'h3008, 0, 7, 10'h3, 0));
        step("afterSF", 0, 0, 0, 0, 0, mk(rv(3), 32'h300C, 1, 8, 10'h4, 0));
        step("flushonly", 0, 0, 1, 0, 0, mk(32'h0, 32'h300C, 0, 8, 10'h5, 0));
        step("afterF", 0, 0, 0, 0, 0, mk(rv(5), 32'h3014, 1, 9, 10'h6, 0));

        rom[2] = 32'h0000_000C;
        step("redir3000", 0, 0, 0, 1, 32'h0000_3000, mk(32'h0, 32'h3014, 0, 9, 10'h0, 0));
        step("sysA", 0, 0, 0, 0, 0, mk(rv(0), 32'h3000, 1, 10, 10'h1, 0));
        step("sysB", 0, 0, 0, 0, 0, mk(rv(1), 32'h3004, 1, 11, 10'h2, 0));
`ifdef IFETCH_SYSCALL_HALT_EN
        step("syscall", 0, 0, 0, 0, 0, mk(32'h0000_000C, 32'h3008, 1, 12, 10'h3, 1));
        for (int k = 0; k < 10; k++)
            step("halted", 0, 0, 0, 0, 0, mk(32'h0, 32'h3008, 0, 12, 10'h3, 1));
        step("haltstall", 0, 1, 0, 0, 0, mk(32'h0, 32'h3008, 0, 12, 10'h3, 1));
        last_pc = 32'h3008;
        cnt     = 12;
`else
        step("syscall", 0, 0, 0, 0, 0, mk(32'h0000_000C, 32'h3008, 1, 12, 10'h3, 0));
        for (int k = 0; k < 10; k++)
            step("nohalt", 0, 0, 0, 0, 0,
                 mk(rv(3 + k), 32'h300C + 32'(4 * k), 1, 32'(13 + k), 10'(4 + k), 0));
        last_pc = 32'h3030;
        cnt     = 22;
`endif
        step("unhalt", 0, 0, 0, 1, 32'h0000_3000, mk(32'h0, last_pc, 0, cnt, 10'h0, 0));
        cnt = cnt + 1;
        step("resumeA", 0, 0, 0, 0, 0, mk(rv(0), 32'h3000, 1, cnt, 10'h1, 0));

        step("redirTop", 0, 0, 0, 1, 32'hFFFF_FFFE, mk(32'h0, 32'h3000, 0, cnt, 10'h3FF, 0));
        cnt = cnt + 1;
        step("pcwrap", 0, 0, 0, 0, 0, mk(rv(1023), 32'hFFFF_FFFC, 1, cnt, 10'h0, 0));

        step("rststall", 1, 1, 0, 1, 32'h0000_3040, mk(32'h0, 32'h0, 0, 0, 10'h0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
